// File: rtl/snake_frame_ctrl.sv
// snake_frame_ctrl: frame sequencer between the game-tick source and the
// framebuffer writer. Divides vsync frame ticks into game steps. For each step
// it sweeps the framebuffer to background, pulses `cleared` to restart the
// snake renderer, then forwards the renderer's pixel stream as writes until
// `write_done` or the draw watchdog expires.
//
// Ports:
//   draw_clk, reset     - clock; asynchronous active-high reset
//   frame_tick          - one-cycle pulse per video frame (synchronous)
//   write_done          - renderer finished streaming (level)
//   rx, ry              - renderer pixel coordinates
//   x, y, color, wr_en  - framebuffer write port (one pixel per cycle)
//   cleared             - one-cycle renderer restart pulse
//   busy                - sequencer not idle
//   overrun, timeout    - sticky: dropped step request / draw watchdog abort
module snake_frame_ctrl #(
  parameter int WIDTH           = 640,
  parameter int HEIGHT          = 480,
  parameter int FRAMES_PER_STEP = 15,
  parameter int DRAW_TIMEOUT    = 20000
) (
  input  logic       draw_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       write_done,
  input  logic [9:0] rx,
  input  logic [8:0] ry,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       color,
  output logic       wr_en,
  output logic       cleared,
  output logic       busy,
  output logic       overrun,
  output logic       timeout
);

  localparam int TW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int WW = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(FRAMES_PER_STEP - 1);
  localparam logic [WW-1:0] WLAST = WW'(DRAW_TIMEOUT - 1);
  localparam logic [9:0]    XLAST = 10'(WIDTH - 1);
  localparam logic [8:0]    YLAST = 9'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ARM, PRIME, DRAW} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          pend_q, pend_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          step_req;
  logic          consume;

  always_ff @(posedge draw_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      wdog_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      wdog_q    <= wdog_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    // Tick divider and one-deep step request. A request arriving in the same
    // cycle that IDLE consumes the previous one simply re-arms `pend`.
    step_req  = frame_tick && (tcnt_q == TLAST);
    consume   = (state_q == IDLE) && pend_q;
    tcnt_d    = frame_tick ? (step_req ? '0 : tcnt_q + 1'b1) : tcnt_q;
    pend_d    = (pend_q && !consume) || step_req;
    overrun_d = overrun_q || (step_req && pend_q && !consume);

    state_d   = state_q;
    wdog_d    = wdog_q;
    x_d       = x_q;
    y_d       = y_q;
    timeout_d = timeout_q;

    x       = x_q;
    y       = y_q;
    color   = 1'b0;
    wr_en   = 1'b0;
    cleared = 1'b0;
    busy    = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          x_d     = '0;
          y_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        if (x_q == XLAST) begin
          x_d = '0;
          if (y_q == YLAST) begin
            y_d     = '0;
            state_d = ARM;
          end else begin
            y_d = y_q + 9'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      ARM: begin
        cleared = 1'b1;
        state_d = PRIME;
      end
      PRIME: begin
        wdog_d  = '0;
        state_d = DRAW;
      end
      DRAW: begin
        x     = rx;
        y     = ry;
        color = 1'b1;
        wr_en = ~write_done;
        if (write_done) begin
          state_d = IDLE;
        end else if (wdog_q == WLAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun = overrun_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_snake_frame_ctrl.sv
// Bench for snake_frame_ctrl: two instances (FRAMES_PER_STEP 1 and 3) on a
// 4x3 screen with an 8-cycle draw watchdog. Each instance has a position-based
// reference model checked every cycle, plus directed literal checks.
module tb_snake_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DT = 8;

  logic       clk;
  logic       rst;
  logic [1:0] tick;
  logic [1:0] wd;
  logic [9:0] rx [2];
  logic [8:0] ry [2];

  int total = 0;
  int bad   = 0;
  int ncl0  = 0;
  int ncl1  = 0;
  int qx[$];
  int qy[$];
  int qc[$];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int FPS = (g == 0) ? 1 : 3;

    logic [9:0] x;
    logic [8:0] y;
    logic       color, wr_en, cleared, busy, overrun, timeout;

    snake_frame_ctrl #(
      .WIDTH(W), .HEIGHT(H), .FRAMES_PER_STEP(FPS), .DRAW_TIMEOUT(DT)
    ) dut (
      .draw_clk(clk), .reset(rst), .frame_tick(tick[g]), .write_done(wd[g]),
      .rx(rx[g]), .ry(ry[g]), .x(x), .y(y), .color(color), .wr_en(wr_en),
      .cleared(cleared), .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    // Model: m_p is the cycle position within a step sequence:
    // [0, W*H) clear pixels, W*H arm, W*H+1 prime, >= W*H+2 draw.
    int m_ticks = 0;
    int m_p     = 0;
    bit m_act   = 1'b0;
    bit m_pend  = 1'b0;
    bit m_ov    = 1'b0;
    bit m_to    = 1'b0;
    bit m_wrap, m_start, e_clr, e_arm, e_drw, e_wr;
    int e_x, e_y;

    assign m_wrap  = tick[g] && (((m_ticks + 1) % FPS) == 0);
    assign m_start = !m_act && m_pend;
    assign e_clr   = m_act && (m_p < W * H);
    assign e_arm   = m_act && (m_p == W * H);
    assign e_drw   = m_act && (m_p >= W * H + 2);
    assign e_wr    = e_clr || (e_drw && !wd[g]);
    assign e_x     = e_clr ? (m_p % W) : (e_drw ? int'(rx[g]) : 0);
    assign e_y     = e_clr ? (m_p / W) : (e_drw ? int'(ry[g]) : 0);

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_ticks <= 0;
        m_p     <= 0;
        m_act   <= 1'b0;
        m_pend  <= 1'b0;
        m_ov    <= 1'b0;
        m_to    <= 1'b0;
      end else begin
        m_ticks <= m_ticks + (tick[g] ? 1 : 0);
        m_pend  <= (m_pend && !m_start) || m_wrap;
        m_ov    <= m_ov || (m_wrap && m_pend && !m_start);
        if (m_start) begin
          m_act <= 1'b1;
          m_p   <= 0;
        end else if (m_act) begin
          if (m_p < W * H + 2) m_p <= m_p + 1;
          else if (wd[g]) m_act <= 1'b0;
          else if (m_p - (W * H + 2) == DT - 1) begin
            m_to  <= 1'b1;
            m_act <= 1'b0;
          end else m_p <= m_p + 1;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("u%0d.busy", g),    int'(busy),    int'(m_act));
      chk($sformatf("u%0d.wr_en", g),   int'(wr_en),   int'(e_wr));
      chk($sformatf("u%0d.color", g),   int'(color),   int'(e_drw));
      chk($sformatf("u%0d.cleared", g), int'(cleared), int'(e_arm));
      chk($sformatf("u%0d.overrun", g), int'(overrun), int'(m_ov));
      chk($sformatf("u%0d.timeout", g), int'(timeout), int'(m_to));
      if (e_wr || rst) begin
        chk($sformatf("u%0d.x", g), int'(x), e_x);
        chk($sformatf("u%0d.y", g), int'(y), e_y);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (u[0].wr_en) begin
        qx.push_back(int'(u[0].x));
        qy.push_back(int'(u[0].y));
        qc.push_back(int'(u[0].color));
      end
      if (u[0].cleared) ncl0 <= ncl0 + 1;
      if (u[1].cleared) ncl1 <= ncl1 + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic tk(input int idx);
    tick[idx] = 1'b1;
    step();
    tick[idx] = 1'b0;
  endtask

  task automatic all_zero0(input string tag);
    chk({tag, ".x"},       int'(u[0].x),       0);
    chk({tag, ".y"},       int'(u[0].y),       0);
    chk({tag, ".color"},   int'(u[0].color),   0);
    chk({tag, ".wr_en"},   int'(u[0].wr_en),   0);
    chk({tag, ".cleared"}, int'(u[0].cleared), 0);
    chk({tag, ".busy"},    int'(u[0].busy),    0);
    chk({tag, ".overrun"}, int'(u[0].overrun), 0);
    chk({tag, ".timeout"}, int'(u[0].timeout), 0);
  endtask

  task automatic wait_idle0(input string tag);
    for (int i = 0; i < 60; i++) begin
      mid();
      if (!u[0].busy) break;
    end
    chk(tag, int'(u[0].busy), 0);
  endtask

  initial begin
    int found, nd, base;
    rst = 1'b1; tick = '0; wd = '0;
    rx[0] = '0; ry[0] = '0; rx[1] = '0; ry[1] = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    mid();
    all_zero0("reset");
    step(); rst = 1'b0;
    repeat (5) step();
    mid();
    chk("idle_busy", int'(u[0].busy), 0);

    // Clear sweep
    step();
    qx.delete(); qy.delete(); qc.delete();
    tk(0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (u[0].cleared) begin found = 1; break; end
    end
    chk("arm_seen", found, 1);
    chk("clr_count", qx.size(), 12);
    for (int i = 0; i < 12 && i < qx.size(); i++) begin
      chk($sformatf("clr%0d.x", i), qx[i], i % 4);
      chk($sformatf("clr%0d.y", i), qy[i], i / 4);
      chk($sformatf("clr%0d.c", i), qc[i], 0);
    end
    chk("last_clr.x", qx[qx.size()-1], 3);
    chk("last_clr.y", qy[qy.size()-1], 2);
    mid();
    chk("prime.wr_en", int'(u[0].wr_en), 0);
    chk("prime.cleared", int'(u[0].cleared), 0);
    chk("prime.busy", int'(u[0].busy), 1);

    // Draw pass-through
    step(); rx[0] = 10'd5; ry[0] = 9'd20; mid();
    chk("draw5.x", int'(u[0].x), 5);
    chk("draw5.y", int'(u[0].y), 20);
    chk("draw5.wr", int'(u[0].wr_en), 1);
    chk("draw5.color", int'(u[0].color), 1);
    step(); rx[0] = 10'd6; mid();
    chk("draw6.x", int'(u[0].x), 6);
    chk("draw6.wr", int'(u[0].wr_en), 1);
    step(); rx[0] = 10'd7; mid();
    chk("draw7.x", int'(u[0].x), 7);
    chk("draw7.wr", int'(u[0].wr_en), 1);
    step(); wd[0] = 1'b1; mid();
    chk("done.wr_en", int'(u[0].wr_en), 0);
    chk("done.busy", int'(u[0].busy), 1);
    step(); wd[0] = 1'b0; mid();
    chk("after_done.busy", int'(u[0].busy), 0);

    // Step divider on the FRAMES_PER_STEP=3 instance
    wd[1] = 1'b1;
    base = ncl1;
    step();
    for (int i = 0; i < 9; i++) begin
      tk(1);
      repeat (30) step();
      if (i == 1) chk("div_after2", ncl1 - base, 0);
    end
    chk("div_sweeps", ncl1 - base, 3);
    chk("div_overrun", int'(u[1].overrun), 0);
    chk("div_busy", int'(u[1].busy), 0);

    // Overrun and timeout
    tk(0);
    repeat (3) step();
    tk(0);
    repeat (3) step();
    tk(0);
    mid();
    chk("overrun_set", int'(u[0].overrun), 1);
    nd = 0; found = 0;
    for (int i = 0; i < 60; i++) begin
      mid();
      if (u[0].wr_en && u[0].color) nd++;
      if (u[0].timeout) begin found = 1; break; end
    end
    chk("timeout_seen", found, 1);
    chk("draw_writes", nd, 8);
    chk("abort.busy", int'(u[0].busy), 0);
    mid();
    chk("pend_serv.busy", int'(u[0].busy), 1);
    chk("pend_serv.wr", int'(u[0].wr_en), 1);
    chk("pend_serv.x", int'(u[0].x), 0);
    chk("pend_serv.y", int'(u[0].y), 0);
    step(); wd[0] = 1'b1;
    wait_idle0("pend_serv_idle");

    // Mid-operation reset at (2,1)
    step();
    tk(0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (u[0].wr_en && u[0].x == 10'd2 && u[0].y == 9'd1) begin found = 1; break; end
    end
    chk("at_2_1", found, 1);
    rst = 1'b1;
    #1;
    all_zero0("midrst");
    step(); step(); rst = 1'b0;
    step();
    tk(0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (u[0].wr_en) begin found = 1; break; end
    end
    chk("restart_seen", found, 1);
    chk("restart.x", int'(u[0].x), 0);
    chk("restart.y", int'(u[0].y), 0);
    wait_idle0("restart_idle");

    // Tick coinciding with IDLE->CLEAR re-arms rather than overruns
    step();
    base = ncl0;
    tick[0] = 1'b1;
    step(); step();
    tick[0] = 1'b0;
    repeat (60) step();
    mid();
    chk("b2b_sweeps", ncl0 - base, 2);
    chk("b2b_overrun", int'(u[0].overrun), 0);
    chk("b2b_busy", int'(u[0].busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not complete");
  end

endmodule
